systolic_feeder_4x4: RTL and testbench

Host-side initiator for the 4x4 systolic array. Latches one A (N×K) and one B (K×N) operand set on a start handshake, pulses the array clear, and drives the diagonally skewed row and column streams with per-lane valids. It then waits for the array's done pulse and captures the saturated C result into a holding register, with a single-cycle result-valid strobe. It sits between the NPU command/operand buffer and the array boundary ports.

---
 rtl/systolic_pkg.sv | 20 ++
 rtl/systolic_skew_lane.sv | 50 +++++
 rtl/systolic_feeder_4x4.sv | 144 ++++++++++++++
 tb/tb_systolic_feeder_4x4.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared defaults and FSM state type for the 4x4 systolic array feeder.
package systolic_pkg;

    localparam int unsigned N_DEF   = 4;
    localparam int unsigned DW_DEF  = 8;
    localparam int unsigned K_DEF   = 4;
    localparam int unsigned CW_DEF  = 16;
    localparam int unsigned TMO_DEF = 64;

    localparam int unsigned BEAT_W  = $clog2(K_DEF + N_DEF);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        WAIT,
        DONE
    } state_t;

endpackage

// File: rtl/systolic_skew_lane.sv
// One skewed operand lane: on beat t emits element t-lane when it lies in 0..K-1.
module systolic_skew_lane
    import systolic_pkg::*;
#(
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned K  = K_DEF,
    parameter int unsigned BW = BEAT_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [K*DW-1:0] elems_i,
    input  logic [BW-1:0]   lane_i,
    input  logic [BW-1:0]   beat_i,
    input  logic            feed_i,
    output logic [DW-1:0]   data_o,
    output logic            valid_o
);

    logic [DW-1:0] data_d, data_q;
    logic          valid_d, valid_q;
    logic [BW-1:0] off;

    always_comb begin
        off     = beat_i - lane_i;
        data_d  = '0;
        valid_d = 1'b0;
        if (feed_i && (beat_i >= lane_i)) begin
            for (int unsigned k = 0; k < K; k++) begin
                if (off == BW'(k)) begin
                    data_d  = elems_i[k*DW +: DW];
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/systolic_feeder_4x4.sv
// Host-side initiator for the 4x4 systolic array: operand latch, skewed feed,
// done/timeout wait and result capture.
module systolic_feeder_4x4
    import systolic_pkg::*;
#(
    parameter int unsigned N   = N_DEF,
    parameter int unsigned DW  = DW_DEF,
    parameter int unsigned K   = K_DEF,
    parameter int unsigned CW  = CW_DEF,
    parameter int unsigned TMO = TMO_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N*K*DW-1:0] a_mat_flat,
    input  logic [K*N*DW-1:0] b_mat_flat,
    output logic              busy,
    output logic              clr,
    output logic [N*DW-1:0]   a_left_flat,
    output logic [N-1:0]      a_v_row_flat,
    output logic [N*DW-1:0]   b_top_flat,
    output logic [N-1:0]      b_v_col_flat,
    input  logic              array_done,
    input  logic [N*N*CW-1:0] c_in_flat,
    output logic [N*N*CW-1:0] c_out_flat,
    output logic              c_valid,
    output logic              err
);

    localparam int unsigned BW = $clog2(K + N);
    localparam int unsigned TW = $clog2(TMO);

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [N*K*DW-1:0] a_q;
    logic [K*N*DW-1:0] b_q;
    logic              busy_q, clr_q, c_valid_q, err_q;
    logic [N*N*CW-1:0] c_out_q;
    logic              accept, done_hit, tmo_hit, feed_d;

    // busy_q also covers the err cycle, where the FSM is already back in IDLE
    assign accept   = (state_q == IDLE) && start && !busy_q;
    assign done_hit = (state_q == WAIT) && array_done;
    assign tmo_hit  = (state_q == WAIT) && !array_done && (tmo_q == TW'(TMO - 1));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tmo_d   = '0;
        unique case (state_q)
            IDLE:  if (accept) state_d = CLEAR;
            CLEAR: begin
                state_d = FEED;
                beat_d  = '0;
            end
            FEED: begin
                if (beat_q == BW'(K + N - 2)) state_d = WAIT;
                else                          beat_d  = beat_q + 1'b1;
            end
            WAIT: begin
                tmo_d = tmo_q + 1'b1;
                if (done_hit)     state_d = DONE;
                else if (tmo_hit) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
            clr_q     <= 1'b0;
            c_valid_q <= 1'b0;
            err_q     <= 1'b0;
            c_out_q   <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            tmo_q     <= tmo_d;
            busy_q    <= (state_d != IDLE) || tmo_hit;
            clr_q     <= (state_d == CLEAR);
            c_valid_q <= done_hit;
            err_q     <= tmo_hit;
            if (done_hit) c_out_q <= c_in_flat;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a_mat_flat;
            b_q <= b_mat_flat;
        end
    end

    // Lanes register from next-state so beat 0 appears the cycle after CLEAR
    assign feed_d = (state_d == FEED);

    logic [N-1:0][K*DW-1:0] col_elems;

    always_comb begin
        col_elems = '0;
        for (int unsigned c = 0; c < N; c++) begin
            for (int unsigned k = 0; k < K; k++) begin
                col_elems[c][k*DW +: DW] = b_q[(k*N + c)*DW +: DW];
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_lane
        systolic_skew_lane #(.DW(DW), .K(K), .BW(BW)) u_row (
            .clk     (clk),
            .rst     (rst),
            .elems_i (a_q[r*K*DW +: K*DW]),
            .lane_i  (BW'(r)),
            .beat_i  (beat_d),
            .feed_i  (feed_d),
            .data_o  (a_left_flat[r*DW +: DW]),
            .valid_o (a_v_row_flat[r])
        );

        systolic_skew_lane #(.DW(DW), .K(K), .BW(BW)) u_col (
            .clk     (clk),
            .rst     (rst),
            .elems_i (col_elems[r]),
            .lane_i  (BW'(r)),
            .beat_i  (beat_d),
            .feed_i  (feed_d),
            .data_o  (b_top_flat[r*DW +: DW]),
            .valid_o (b_v_col_flat[r])
        );
    end

    assign busy       = busy_q;
    assign clr        = clr_q;
    assign c_valid    = c_valid_q;
    assign err        = err_q;
    assign c_out_flat = c_out_q;

endmodule

// File: tb/tb_systolic_feeder_4x4.sv
// Directed bench for systolic_feeder_4x4 with a cycle-offset reference model.
module tb_systolic_feeder_4x4;

    localparam int N   = systolic_pkg::N_DEF;
    localparam int DW  = systolic_pkg::DW_DEF;
    localparam int K   = systolic_pkg::K_DEF;
    localparam int CW  = systolic_pkg::CW_DEF;
    localparam int TMO = systolic_pkg::TMO_DEF;

    logic              clk = 1'b0;
    logic              rst, start, array_done;
    logic [N*K*DW-1:0] a_mat_flat;
    logic [K*N*DW-1:0] b_mat_flat;
    logic [N*N*CW-1:0] c_in_flat;
    logic              busy, clr, c_valid, err;
    logic [N*DW-1:0]   a_left_flat, b_top_flat;
    logic [N-1:0]      a_v_row_flat, b_v_col_flat;
    logic [N*N*CW-1:0] c_out_flat;

    systolic_feeder_4x4 dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a_mat_flat   (a_mat_flat),
        .b_mat_flat   (b_mat_flat),
        .busy         (busy),
        .clr          (clr),
        .a_left_flat  (a_left_flat),
        .a_v_row_flat (a_v_row_flat),
        .b_top_flat   (b_top_flat),
        .b_v_col_flat (b_v_col_flat),
        .array_done   (array_done),
        .c_in_flat    (c_in_flat),
        .c_out_flat   (c_out_flat),
        .c_valid      (c_valid),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Lane contents for beat t straight from the skew rule.
    function automatic logic [N*DW-1:0] row_data(input logic [N*K*DW-1:0] a, input int t);
        row_data = '0;
        for (int r = 0; r < N; r++)
            if (t - r >= 0 && t - r < K) row_data[r*DW +: DW] = a[(r*K + t - r)*DW +: DW];
    endfunction

    function automatic logic [N*DW-1:0] col_data(input logic [K*N*DW-1:0] b, input int t);
        col_data = '0;
        for (int c = 0; c < N; c++)
            if (t - c >= 0 && t - c < K) col_data[c*DW +: DW] = b[((t - c)*N + c)*DW +: DW];
    endfunction

    function automatic logic [N-1:0] lane_v(input int t);
        lane_v = '0;
        for (int i = 0; i < N; i++)
            if (t - i >= 0 && t - i < K) lane_v[i] = 1'b1;
    endfunction

    function automatic logic [N*N*CW-1:0] matmul(input logic [N*K*DW-1:0] a, input logic [K*N*DW-1:0] b);
        int acc;
        matmul = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                acc = 0;
                for (int k = 0; k < K; k++)
                    acc = acc + int'($signed(a[(r*K + k)*DW +: DW])) * int'($signed(b[(k*N + c)*DW +: DW]));
                if (acc > 32767) acc = 32767;
                if (acc < -32768) acc = -32768;
                matmul[(r*N + c)*CW +: CW] = 16'(acc);
            end
    endfunction

    // Reference model: expectations for the next cycle, keyed on the offset
    // from the accepting cycle.
    int                cyc = 0;
    int                m_s = 0;
    bit                m_act = 1'b0;
    bit                m_fin = 1'b0;
    logic [N*K*DW-1:0] m_a;
    logic [K*N*DW-1:0] m_b;
    logic              e_busy, e_clr, e_cv, e_err;
    logic [N*DW-1:0]   e_a, e_b;
    logic [N-1:0]      e_av, e_bv;
    logic [N*N*CW-1:0] e_cout;

    always @(posedge clk) begin
        e_clr <= 1'b0; e_cv <= 1'b0; e_err <= 1'b0;
        e_a <= '0; e_b <= '0; e_av <= '0; e_bv <= '0;
        if (rst) begin
            m_act <= 1'b0; m_fin <= 1'b0; e_busy <= 1'b0; e_cout <= '0;
        end else if (m_fin) begin
            m_act <= 1'b0; m_fin <= 1'b0; e_busy <= 1'b0;
        end else if (!m_act) begin
            e_busy <= start;
            e_clr  <= start;
            if (start) begin
                m_act <= 1'b1; m_s <= cyc; m_a <= a_mat_flat; m_b <= b_mat_flat;
            end
        end else begin
            e_busy <= 1'b1;
            if (cyc + 1 - m_s >= 2 && cyc + 1 - m_s <= K + N) begin
                e_a  <= row_data(m_a, cyc - 1 - m_s);
                e_b  <= col_data(m_b, cyc - 1 - m_s);
                e_av <= lane_v(cyc - 1 - m_s);
                e_bv <= lane_v(cyc - 1 - m_s);
            end else if (cyc - m_s >= K + N + 1) begin
                if (array_done) begin
                    e_cv <= 1'b1; e_cout <= c_in_flat; m_fin <= 1'b1;
                end else if (cyc - m_s - (K + N + 1) == TMO - 1) begin
                    e_err <= 1'b1; m_fin <= 1'b1;
                end
            end
        end
        cyc <= cyc + 1;
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",    256'(busy),         256'(e_busy));
            check("clr",     256'(clr),          256'(e_clr));
            check("a_left",  256'(a_left_flat),  256'(e_a));
            check("a_v_row", 256'(a_v_row_flat), 256'(e_av));
            check("b_top",   256'(b_top_flat),   256'(e_b));
            check("b_v_col", 256'(b_v_col_flat), 256'(e_bv));
            check("c_valid", 256'(c_valid),      256'(e_cv));
            check("err",     256'(err),          256'(e_err));
            check("c_out",   256'(c_out_flat),   256'(e_cout));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    int exp_r0[7] = '{1, 0, 0, 0, 0, 0, 0};
    int exp_c3[7] = '{0, 0, 0, 1, 1, 1, 1};

    initial begin
        logic [N*K*DW-1:0] sa;
        logic [K*N*DW-1:0] sb;
        int n, clr_cyc, err_cyc, ncv;
        bit found;

        rst = 1'b1; start = 1'b0; array_done = 1'b0;
        a_mat_flat = '0; b_mat_flat = '0; c_in_flat = '0;
        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_busy",  256'(busy), 256'(0));
        check("rst_c_out", 256'(c_out_flat), 256'(0));
        check("rst_valid", 256'({a_v_row_flat, b_v_col_flat, c_valid, err, clr}), 256'(0));
        rst = 1'b0;
        tick();

        // Identity A, B[k][c] = 4k+c+1
        sa = '0; sb = '0;
        for (int r = 0; r < N; r++) sa[(r*K + r)*DW +: DW] = 8'd1;
        for (int k = 0; k < K; k++)
            for (int c = 0; c < N; c++) sb[(k*N + c)*DW +: DW] = 8'(4*k + c + 1);
        a_mat_flat = sa; b_mat_flat = sb; start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_clr", 256'(clr), 256'(1));
        check("t1_busy", 256'(busy), 256'(1));
        a_mat_flat = {$urandom, $urandom, $urandom, $urandom};
        b_mat_flat = {$urandom, $urandom, $urandom, $urandom};
        for (int t = 0; t < K + N - 1; t++) begin
            tick();
            check($sformatf("t1_row0_t%0d", t), 256'(a_left_flat[7:0]), 256'(exp_r0[t]));
            check($sformatf("t1_col3v_t%0d", t), 256'(b_v_col_flat[3]), 256'(exp_c3[t]));
        end
        repeat (3) tick();
        c_in_flat = matmul(sa, sb); array_done = 1'b1;
        tick();
        array_done = 1'b0;
        check("t1_c_valid", 256'(c_valid), 256'(1));
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                check($sformatf("t1_c%0d%0d", r, c), 256'(c_out_flat[(r*N + c)*CW +: CW]), 256'(4*r + c + 1));
        tick();
        check("t1_idle", 256'({busy, c_valid}), 256'(0));

        // All -128 operands
        sa = {N*K{8'h80}}; sb = {K*N{8'h80}};
        a_mat_flat = sa; b_mat_flat = sb; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t2_a0", 256'(a_left_flat[7:0]), 256'(8'h80));
        check("t2_a1", 256'(a_left_flat[15:8]), 256'(0));
        check("t2_av", 256'(a_v_row_flat), 256'(4'b0001));
        check("t2_b0", 256'(b_top_flat[7:0]), 256'(8'h80));
        check("t2_bv", 256'(b_v_col_flat), 256'(4'b0001));
        repeat (9) tick();
        c_in_flat = matmul(sa, sb); array_done = 1'b1;
        tick();
        array_done = 1'b0;
        check("t2_c_valid", 256'(c_valid), 256'(1));
        check("t2_sat00", 256'(c_out_flat[15:0]), 256'(16'h7FFF));
        check("t2_sat33", 256'(c_out_flat[255:240]), 256'(16'h7FFF));
        tick();

        // start held high
        start = 1'b1; n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (clr) n++;
        end
        check("t3_one_accept", 256'(n), 256'(1));
        check("t3_busy", 256'(busy), 256'(1));
        c_in_flat = {8{$urandom}}; array_done = 1'b1;
        tick();
        array_done = 1'b0;
        check("t3_c_valid", 256'(c_valid), 256'(1));
        tick();
        check("t3_gap", 256'({busy, clr}), 256'(0));
        tick();
        check("t3_reaccept", 256'(clr), 256'(1));
        clr_cyc = cyc;
        start = 1'b0;

        // array_done held low: timeout
        found = 1'b0; ncv = 0; err_cyc = 0;
        for (int i = 0; i < K + N + TMO + 10; i++) begin
            tick();
            if (c_valid) ncv++;
            if (err) begin
                found = 1'b1; err_cyc = cyc; break;
            end
        end
        check("t4_err_seen", 256'(found), 256'(1));
        check("t4_err_cycle", 256'(err_cyc - clr_cyc), 256'(K + N + TMO));
        check("t4_no_cvalid", 256'(ncv), 256'(0));
        check("t4_busy_err", 256'(busy), 256'(1));
        tick();
        check("t4_busy_drop", 256'({busy, err}), 256'(0));

        // array_done coincident with timeout
        for (int r = 0; r < N; r++)
            for (int k = 0; k < K; k++) begin
                sa[(r*K + k)*DW +: DW] = 8'(3*r - 5*k);
                sb[(k*N + r)*DW +: DW] = 8'(k - 2*r);
            end
        a_mat_flat = sa; b_mat_flat = sb; start = 1'b1;
        tick();
        start = 1'b0;
        check("t5_clr", 256'(clr), 256'(1));
        repeat (K + N + TMO - 1) tick();
        c_in_flat = matmul(sa, sb); array_done = 1'b1;
        tick();
        array_done = 1'b0;
        check("t5_c_valid", 256'(c_valid), 256'(1));
        check("t5_no_err", 256'(err), 256'(0));
        tick();
        check("t5_idle", 256'({busy, err}), 256'(0));

        // reset mid-FEED at beat 3
        a_mat_flat = {4{$urandom}}; b_mat_flat = {4{$urandom}}; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("t6_beat3_v", 256'({a_v_row_flat, b_v_col_flat}), 256'(8'hFF));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_v", 256'({a_v_row_flat, b_v_col_flat}), 256'(0));
        check("t6_rst_busy", 256'(busy), 256'(0));
        check("t6_rst_c_out", 256'(c_out_flat), 256'(0));
        for (int r = 0; r < N; r++)
            for (int k = 0; k < K; k++) begin
                sa[(r*K + k)*DW +: DW] = 8'(r + k + 1);
                sb[(k*N + r)*DW +: DW] = (k == r) ? 8'd2 : 8'd0;
            end
        a_mat_flat = sa; b_mat_flat = sb; start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_clr", 256'(clr), 256'(1));
        repeat (10) tick();
        c_in_flat = matmul(sa, sb); array_done = 1'b1;
        tick();
        array_done = 1'b0;
        check("t6_c_valid", 256'(c_valid), 256'(1));
        check("t6_c00", 256'(c_out_flat[15:0]), 256'(2));
        tick();
        check("t6_idle", 256'(busy), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
